// File: rtl/iob_axistream_out_conv_pkg.sv
// Shared constants for the AXI-Stream output converter: FSM encodings and lane-width helper.
package iob_axistream_out_conv_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Lane index width, never narrower than one bit so N==1 still has a port.
    function automatic int unsigned lane_w_f(input int unsigned n_lanes);
        return (n_lanes <= 1) ? 1 : $clog2(n_lanes);
    endfunction

endpackage

// File: rtl/iob_axistream_out_unpack.sv
// Unpacker: holds one FIFO word and walks its valid lanes onto the AXIS beat interface.
// Lane order reverses when IOB_AXISTREAM_OUT_CONV_MSB_FIRST_EN is defined.
module iob_axistream_out_unpack
    import iob_axistream_out_conv_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TDATA_W = 8,
    localparam int unsigned N_LANES = DATA_W / TDATA_W,
    localparam int unsigned LANE_W  = lane_w_f(N_LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soft_rst,
    input  logic                     fifo_empty,
    input  logic [DATA_W+LANE_W:0]   fifo_rdata,
    output logic                     pop_c,
    input  logic                     tready,
    output logic [TDATA_W-1:0]       tdata,
    output logic                     tvalid,
    output logic                     tlast,
    output logic                     busy
);

    logic [0:0]        state, state_nxt;
    logic [DATA_W-1:0] hold_data;
    logic [LANE_W-1:0] hold_end;
    logic              hold_last;
    logic [LANE_W-1:0] lane, lane_nxt;
    logic              load_c;
    logic              final_c;
    logic [LANE_W-1:0] start_c;
    logic [LANE_W-1:0] step_c;

    logic [DATA_W-1:0] rd_data;
    logic [LANE_W-1:0] rd_end;
    logic              rd_last;

    assign rd_data = fifo_rdata[DATA_W-1:0];
    assign rd_end  = fifo_rdata[DATA_W +: LANE_W];
    assign rd_last = fifo_rdata[DATA_W+LANE_W];

`ifdef IOB_AXISTREAM_OUT_CONV_MSB_FIRST_EN
    assign start_c = rd_end;
    assign final_c = (lane == '0);
    assign step_c  = lane - LANE_W'(1);
`else
    assign start_c = '0;
    assign final_c = (lane == hold_end);
    assign step_c  = lane + LANE_W'(1);
`endif

    // Next-state: a word is popped on entry from IDLE and straight after each final lane.
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        load_c    = 1'b0;
        pop_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    load_c    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tready) begin
                    if (final_c) begin
                        if (!fifo_empty) begin
                            pop_c  = 1'b1;
                            load_c = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        lane_nxt = step_c;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (load_c) begin
            lane_nxt = start_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lane      <= '0;
            hold_data <= '0;
            hold_end  <= '0;
            hold_last <= 1'b0;
        end else if (soft_rst) begin
            state     <= ST_IDLE;
            lane      <= '0;
            hold_data <= '0;
            hold_end  <= '0;
            hold_last <= 1'b0;
        end else begin
            state <= state_nxt;
            lane  <= lane_nxt;
            if (load_c) begin
                hold_data <= rd_data;
                hold_end  <= rd_end;
                hold_last <= rd_last;
            end
        end
    end

    // Beat outputs decode registers only; tready never reaches tvalid.
    assign tvalid = (state == ST_SEND);
    assign tdata  = hold_data[32'(lane) * TDATA_W +: TDATA_W];
    assign tlast  = hold_last & final_c;
    assign busy   = (state == ST_SEND);

endmodule

// File: rtl/iob_axistream_out_conv.sv
// CPU-to-AXI-Stream output stage: register-array FIFO of words feeding the lane unpacker.
// Optional macro: IOB_AXISTREAM_OUT_CONV_MSB_FIRST_EN (highest valid lane emitted first).
module iob_axistream_out_conv
    import iob_axistream_out_conv_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TDATA_W     = 8,
    parameter int unsigned FIFO_ADDR_W = 4,
    localparam int unsigned N_LANES = DATA_W / TDATA_W,
    localparam int unsigned LANE_W  = lane_w_f(N_LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    input  logic [LANE_W-1:0]      in_nlanes,
    output logic [TDATA_W-1:0]     tdata,
    output logic                   tvalid,
    input  logic                   tready,
    output logic                   tlast,
    output logic [FIFO_ADDR_W:0]   level,
    output logic                   empty
);

    localparam int unsigned ENTRY_W = DATA_W + LANE_W + 1;
    localparam int unsigned DEPTH   = 2 ** FIFO_ADDR_W;

    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wptr, rptr;
    logic                   full_c, fifo_empty_c, push_c, pop_c, busy;
    logic [LANE_W-1:0]      end_c;

    assign full_c       = (level == (FIFO_ADDR_W+1)'(DEPTH));
    assign fifo_empty_c = (level == '0);
    assign in_ready     = ~full_c;
    assign push_c       = in_valid & ~full_c;
    assign end_c        = (N_LANES == 1) ? '0 : (in_last ? in_nlanes : LANE_W'(N_LANES - 1));
    assign empty        = fifo_empty_c & ~busy;

    // Pointers and occupancy; soft_rst overrides any push/pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (soft_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_c) begin
                wptr <= wptr + FIFO_ADDR_W'(1);
            end
            if (pop_c) begin
                rptr <= rptr + FIFO_ADDR_W'(1);
            end
            level <= level + (FIFO_ADDR_W+1)'(push_c) - (FIFO_ADDR_W+1)'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !soft_rst) begin
            mem[wptr] <= {in_last, end_c, in_data};
        end
    end

    iob_axistream_out_unpack #(
        .DATA_W  (DATA_W),
        .TDATA_W (TDATA_W)
    ) u_unpack (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .fifo_empty (fifo_empty_c),
        .fifo_rdata (mem[rptr]),
        .pop_c      (pop_c),
        .tready     (tready),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tlast      (tlast),
        .busy       (busy)
    );

endmodule
